// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB field offsets and the MEM-stage FSM state type.
package pipeline_pkg;

   localparam int unsigned REG_IDX_W = 4;

   // EX/MEM field offsets relative to the top of rd3 (absolute bit = N + offset)
   localparam int unsigned EX_RC_REL   = 0;
   localparam int unsigned EX_RB_REL   = 4;
   localparam int unsigned EX_RA_REL   = 8;
   localparam int unsigned EX_RW_REL   = 12;
   localparam int unsigned EX_MTR_REL  = 13;
   localparam int unsigned EX_MW_REL   = 14;
   localparam int unsigned EX_BR_REL   = 15;
   localparam int unsigned EX_NEG_REL  = 16;
   localparam int unsigned EX_ZERO_REL = 17;
   localparam int unsigned EX_ALU_REL  = 18;

   // MEM/WB field offsets from bit 0 (rdataSel sits at N + WB_ALU_OFF)
   localparam int unsigned WB_RA_OFF   = 0;
   localparam int unsigned WB_RW_OFF   = 4;
   localparam int unsigned WB_MTR_OFF  = 5;
   localparam int unsigned WB_ALU_OFF  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } mem_state_e;

endpackage

// File: rtl/buffer.sv
// Generic enabled pipeline register with synchronous active-high reset.
module buffer #(
   parameter int unsigned Buffer_size = 70
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [Buffer_size-1:0] i_d,
   output logic [Buffer_size-1:0] o_q
);

   logic [Buffer_size-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst)     r_q <= '0;
      else if (en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory req/ack access with timeout, branch resolve, MEM/WB register.
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned BW_IN   = 2*N + 18,
   parameter int unsigned BW_OUT  = 2*N + 6,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [BW_IN-1:0]  exMemIn,
   input  logic [N-1:0]      memRdata,
   input  logic              memAck,
   output logic              memReq,
   output logic              memWe,
   output logic [N-1:0]      memAddr,
   output logic [N-1:0]      memWdata,
   output logic              memBusy,
   output logic [N-1:0]      aluOutFwd,
   output logic              branchTaken,
   output logic [N-1:0]      branchTarget,
   output logic              memErr,
   output logic [BW_OUT-1:0] bufferOut
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [N-1:0]         w_alu;
   logic [N-1:0]         w_rd3;
   logic [REG_IDX_W-1:0] w_ra;
   logic                 w_zero, w_br, w_mw, w_mtr, w_rw, w_need_mem;
   logic                 w_unused_fields;

   assign w_alu      = exMemIn[N+EX_ALU_REL +: N];
   assign w_zero     = exMemIn[N+EX_ZERO_REL];
   assign w_br       = exMemIn[N+EX_BR_REL];
   assign w_mw       = exMemIn[N+EX_MW_REL];
   assign w_mtr      = exMemIn[N+EX_MTR_REL];
   assign w_rw       = exMemIn[N+EX_RW_REL];
   assign w_ra       = exMemIn[N+EX_RA_REL +: REG_IDX_W];
   assign w_rd3      = exMemIn[N-1:0];
   assign w_need_mem = w_mw | w_mtr;
   assign w_unused_fields = ^{exMemIn[N+EX_NEG_REL], exMemIn[N+EX_RB_REL +: REG_IDX_W],
                              exMemIn[N+EX_RC_REL +: REG_IDX_W]};

   assign aluOutFwd    = w_alu;
   assign branchTarget = w_alu;
   assign branchTaken  = w_br & w_zero;

   mem_state_e       r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_rdata, r_addr, r_wdata, w_rdata_sel;
   logic             r_req, r_we, r_err;
   logic             w_issue, w_ack_hit, w_timeout, w_cnt_max, w_busy;

   assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT));

   // Next state, access events, busy and the rdata selected into MEM/WB
   always_comb begin
      w_next      = r_state;
      w_issue     = 1'b0;
      w_ack_hit   = 1'b0;
      w_timeout   = 1'b0;
      w_busy      = 1'b0;
      w_rdata_sel = '0;
      case (r_state)
         ST_IDLE: begin
            w_busy = w_need_mem;
            if (w_need_mem && en) begin
               w_issue = 1'b1;
               w_next  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (memAck) begin
               w_ack_hit   = 1'b1;
               w_rdata_sel = w_mtr ? memRdata : '0;
               w_next      = en ? ST_IDLE : ST_HOLD;
            end else if (w_cnt_max) begin
               w_timeout = 1'b1;
               w_next    = en ? ST_IDLE : ST_HOLD;
            end else begin
               w_busy = 1'b1;
            end
         end
         ST_HOLD: begin
            w_rdata_sel = r_rdata;
            if (en) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State, request interface, wait counter, captured rdata and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_req   <= (w_next == ST_WAIT);
         if (w_issue) begin
            r_addr  <= w_alu;
            r_wdata <= w_rd3;
            r_we    <= w_mw;
            r_cnt   <= '0;
         end else if (w_next != ST_WAIT) begin
            r_we <= 1'b0;
         end
         if (r_state == ST_WAIT && !memAck && !w_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
         if (w_ack_hit) r_rdata <= w_rdata_sel;
         else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   assign memReq   = r_req;
   assign memWe    = r_we;
   assign memAddr  = r_addr;
   assign memWdata = r_wdata;
   assign memErr   = r_err;
   assign memBusy  = w_busy;

   buffer #(.Buffer_size(BW_OUT)) u_mem_wb (
      .clk (clk),
      .rst (rst),
      .en  (en & ~w_busy),
      .i_d ({w_rdata_sel, w_alu, w_mtr, w_rw, w_ra}),
      .o_q (bufferOut)
   );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the EX/MEM bundle, performs the data-memory access over a req/ack handshake with a timeout, and resolves branch taken.
- Loads the MEM/WB register for writeback and drives the forwarding value and the stall request for the hazard unit.

Parameters:
N, 32, datapath/word width
BW_IN, 2*N+18, EX/MEM bundle width (82 at default)
BW_OUT, 2*N+6, MEM/WB bundle width
TIMEOUT, 15, max WAIT cycles without ack before abort (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  global pipeline advance (0 = stall from hazard unit)
exMemIn  input  BW_IN  EX/MEM bundle; upstream holds it stable while memBusy=1
memRdata  input  N  data-memory read data, valid with memAck
memAck  input  1  data-memory completion, single-cycle pulse
memReq  output  1  data-memory request
memWe  output  1  1 = store
memAddr  output  N  access address
memWdata  output  N  store data
memBusy  output  1  stall request to hazard unit
aluOutFwd  output  N  ALU result of the instruction in MEM (forwarding)
branchTaken  output  1  branch resolved taken
branchTarget  output  N  taken target (= ALU result)
memErr  output  1  sticky access-timeout flag
bufferOut  output  BW_OUT  MEM/WB register

Behaviour:
- exMemIn layout, MSB to LSB: aluRes[N], zeroFlag, negFlag, branchFlag, memWrite, memToReg, regWrite, Ra[4], Rb[4], Rc[4], rd3[N].
- Ra is the destination register; rd3 is store data.
- needMem = memWrite | memToReg.
- Combinational outputs:
  - aluOutFwd = aluRes.
  - branchTarget = aluRes.
  - branchTaken = branchFlag & zeroFlag.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, needMem & en: latch memAddr=aluRes, memWdata=rd3, memWe=memWrite; clear wait counter; go to WAIT.
  - IDLE, !needMem: stay in IDLE; no request.
  - WAIT: memReq=1.
    - On memAck: capture rdata (memRdata for loads, 0 for stores); memReq drops next cycle. If en=1 go to IDLE (access complete); else go to HOLD.
    - No ack: increment counter. At counter==TIMEOUT: set memErr, captured rdata=0; go to IDLE if en=1, else HOLD.
  - HOLD: no request; wait for en=1, then go to IDLE.
  - HOLD prevents re-issuing a completed access while the pipeline is stalled.
- memBusy (combinational) is 1 when:
  - needMem & state==IDLE, or
  - state==WAIT & !memAck & counter!=TIMEOUT.
  - memBusy=0 in HOLD.
- MEM/WB register:
  - Loads when en=1 & memBusy=0.
  - Otherwise holds its value.
  - Layout: {rdataSel[N], aluRes[N], memToReg, regWrite, Ra}.
  - rdataSel is the captured rdata for mem ops, 0 otherwise.
- Latency:
  - Non-memory op: 1 cycle (EX/MEM to MEM/WB).
  - Memory op: 1 + k cycles, where k = ack delay in cycles counted from the first WAIT cycle (k>=1).
- Ack while not in WAIT: ignored.
- memErr clears only on rst.
- Reset, including mid-access: on the next edge state=IDLE, memReq/memWe=0, memAddr/memWdata=0, counter=0, memErr=0, bufferOut=0. Any late ack is ignored.
- memReq, memWe, memAddr and memWdata are registered (glitch-free).

Decomposition:
- Shared package pipeline_pkg:
  - field offset/width localparams for the EX/MEM and MEM/WB bundles.
  - mem FSM state enum.
  - REG_IDX_W=4.
- MEM/WB register reuses the existing buffer module (Buffer_size=BW_OUT), with en = en & !memBusy.
- The FSM and counter stay inline; no further sub-module.

Test Plan:
- ALU op (aluRes=0x10, regWrite=1, Ra=3, needMem=0, en=1) -> next cycle bufferOut={0,0x10,0,1,3}; memReq never asserted; memBusy=0.
- Load (memToReg=1, aluRes=0x40), memAck 2 cycles after memReq rises with memRdata=0xDEADBEEF:
  - memBusy=1 for 3 cycles; memAddr=0x40, memWe=0.
  - bufferOut rdata field=0xDEADBEEF one edge after ack.
  - Exactly one request.
- Store (memWrite=1, aluRes=0x8, rd3=0x55), ack 1 cycle after request -> memWe=1, memWdata=0x55; bufferOut rdata=0; regWrite passes through.
- Load with en=0 held during and 3 cycles after ack -> FSM in HOLD; memReq low; no second request; bufferOut unchanged until en=1.
- No ack, TIMEOUT=15 -> memReq high exactly 16 cycles (counter 0-15); memErr=1 sticky; memBusy drops; rdata=0; memErr survives later accesses until rst.
- rst asserted in WAIT cycle 2, then an ack pulse -> next edge memReq=0, bufferOut=0, memErr=0; ack ignored; branchFlag=1 & zeroFlag=1 with aluRes=0x100 -> branchTaken=1, branchTarget=0x100.
